acc_stream_feeder: RTL and testbench

//   Upstream feeder for the accumulator. Accepts samples on a valid/ready stream

---
 rtl/acc_stream_feeder.sv | 141 ++++++++++++++
 tb/tb_acc_stream_feeder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_stream_feeder.sv
// Stream-to-accumulator feeder: FIFO-buffers framed valid/ready samples, drains one per
// cycle onto enable/data, inserts an idle gap between frames and reports each frame's length.
module acc_stream_feeder #(
    parameter int DATA_WD    = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_GAP  = 1,
    parameter int CNT_WD     = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DATA_WD-1:0]            i_data,
    input  logic                          i_last,
    input  logic                          i_hold,
    output logic                          o_enable,
    output logic [DATA_WD-1:0]            o_data,
    output logic                          o_frame_done,
    output logic [CNT_WD-1:0]             o_frame_len,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [AW:0]       CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [CNT_WD-1:0] LEN_MAX  = '1;
    localparam logic [CNT_WD-1:0] LEN_ONE  = CNT_WD'(1);
    localparam logic [GW-1:0]     GAP_ONE  = GW'(1);
    localparam logic [GW-1:0]     GAP_LOAD = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    localparam bit                GAP_EN   = (FRAME_GAP > 0);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        GAP
    } state_t;

    state_t state, state_nxt;
    logic [GW-1:0]     gap_cnt, gap_nxt;

    logic [DATA_WD:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_WD:0]  head;
    logic              head_last;
    logic              push, pop;

    logic [CNT_WD-1:0] len_cnt, len_inc, len_pend;
    logic              last_q;

    assign head      = mem[rd_ptr];
    assign head_last = head[DATA_WD];

    // No pass-through: readiness comes only from the registered occupancy.
    assign o_ready = i_rstn && (o_count != CNT_FULL);
    assign push    = i_valid && o_ready;
    assign pop     = (o_count != '0) && !i_hold && (state != GAP);

    assign len_inc = (len_cnt == LEN_MAX) ? LEN_MAX : len_cnt + LEN_ONE;

    // NOTE: every variable driven here gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        case (state)
            IDLE, DRAIN: begin
                if (GAP_EN && pop && head_last) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_LOAD;
                end else if (o_count != '0) begin
                    state_nxt = DRAIN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = (o_count != '0) ? DRAIN : IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the sample storage is deliberately not reset; the pointers and count make stale entries unreachable.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_last, i_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_count      <= '0;
            o_enable     <= 1'b0;
            o_data       <= '0;
            len_cnt      <= '0;
            len_pend     <= '0;
            last_q       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_len  <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   o_count <= o_count + CNT_ONE;
                2'b01:   o_count <= o_count - CNT_ONE;
                default: o_count <= o_count;
            endcase

            o_enable <= pop;
            if (pop) o_data <= head[DATA_WD-1:0];

            if (pop) begin
                if (head_last) begin
                    len_pend <= len_inc;
                    len_cnt  <= '0;
                end else begin
                    len_cnt  <= len_inc;
                end
            end

            // Done trails the last sample's enable by one cycle, once the accumulator holds it.
            last_q       <= pop && head_last;
            o_frame_done <= last_q;
            if (last_q) o_frame_len <= len_pend;
        end
    end

endmodule

// File: tb/tb_acc_stream_feeder.sv
// Self-checking bench for acc_stream_feeder: table vectors, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_acc_stream_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int GAP_A = 2;
    localparam int CW_A  = 4;
    localparam int CW_B  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn, valid, last, hold;
    logic [DW-1:0] data;

    logic            a_ready, a_en, a_done;
    logic [DW-1:0]   a_data;
    logic [CW_A-1:0] a_len;
    logic [3:0]      a_count;

    logic            b_ready, b_en, b_done;
    logic [DW-1:0]   b_data;
    logic [CW_B-1:0] b_len;
    logic [3:0]      b_count;

    acc_stream_feeder #(.DATA_WD(DW), .FIFO_DEPTH(DEPTH), .FRAME_GAP(GAP_A), .CNT_WD(CW_A)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(a_ready), .i_data(data),
        .i_last(last), .i_hold(hold), .o_enable(a_en), .o_data(a_data),
        .o_frame_done(a_done), .o_frame_len(a_len), .o_count(a_count)
    );

    acc_stream_feeder #(.DATA_WD(DW), .FIFO_DEPTH(DEPTH), .FRAME_GAP(0), .CNT_WD(CW_B)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(b_ready), .i_data(data),
        .i_last(last), .i_hold(hold), .o_enable(b_en), .o_data(b_data),
        .o_frame_done(b_done), .o_frame_len(b_len), .o_count(b_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            rstn, valid;
        logic [DW-1:0]   data;
        logic            last, hold;
        logic            en;
        logic [DW-1:0]   dat;
        logic            done;
        logic [CW_A-1:0] len;
        logic [3:0]      cnt;
        logic            rdy;
    } vec_t;

    vec_t tbl [7];

    // Reference model state
    logic [DW:0] mq [$];
    int          gap_left, fcnt, pend_len;
    logic        pend_pulse;
    logic        e_en, e_done;
    logic [DW-1:0] e_data;
    int          e_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic l, input logic h);
        rstn  = r;
        valid = v;
        data  = d;
        last  = l;
        hold  = h;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_clear();
        mq.delete();
        gap_left   = 0;
        fcnt       = 0;
        pend_len   = 0;
        pend_pulse = 1'b0;
        e_en       = 1'b0;
        e_done     = 1'b0;
        e_data     = '0;
        e_len      = 0;
    endtask

    // Advance the model over one clock edge using the inputs presented before it.
    task automatic model_edge(input logic r, input logic v, input logic [DW-1:0] d, input logic l, input logic h);
        logic        m_push, can_pop, was_pulse;
        logic [DW:0] ent;
        if (!r) begin
            model_clear();
        end else begin
            m_push    = v && (mq.size() < DEPTH);
            can_pop   = (mq.size() > 0) && !h && (gap_left == 0);
            was_pulse = pend_pulse;
            if (pend_pulse) e_len = pend_len;
            pend_pulse = 1'b0;
            if (gap_left > 0) gap_left--;
            e_en = 1'b0;
            if (can_pop) begin
                ent    = mq.pop_front();
                e_en   = 1'b1;
                e_data = ent[DW-1:0];
                fcnt   = (fcnt + 1 > (2**CW_A) - 1) ? (2**CW_A) - 1 : fcnt + 1;
                if (ent[DW]) begin
                    pend_len   = fcnt;
                    pend_pulse = 1'b1;
                    fcnt       = 0;
                    gap_left   = GAP_A;
                end
            end
            e_done = was_pulse;
            if (m_push) mq.push_back({l, d});
        end
    endtask

    initial begin
        // ---------- Test 1: reset then a 3-sample frame, table driven ----------
        tbl[0] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 4'd0, 4'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 4'd0, 4'd1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 32'd20, 1'b0, 1'b0, 1'b1, 32'd10, 1'b0, 4'd0, 4'd1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 32'd64, 1'b1, 1'b0, 1'b1, 32'd20, 1'b0, 4'd0, 4'd1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 32'd64, 1'b0, 4'd0, 4'd0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd64, 1'b1, 4'd3, 4'd0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'd64, 1'b0, 4'd3, 4'd0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].rstn, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].hold);
            step();
            check($sformatf("t1[%0d].enable", i), a_en,    tbl[i].en);
            check($sformatf("t1[%0d].data", i),   a_data,  tbl[i].dat);
            check($sformatf("t1[%0d].done", i),   a_done,  tbl[i].done);
            check($sformatf("t1[%0d].len", i),    a_len,   tbl[i].len);
            check($sformatf("t1[%0d].count", i),  a_count, tbl[i].cnt);
            check($sformatf("t1[%0d].ready", i),  a_ready, tbl[i].rdy);
        end

        // ---------- Test 2: fill under hold, then drain 8 back-to-back ----------
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, DW'(100 + k), 1'b0, 1'b1);
            step();
            check($sformatf("t2.fill[%0d].count", k), a_count, (k < 8) ? k + 1 : 8);
        end
        check("t2.full.ready", a_ready, 1'b0);
        check("t2.full.enable", a_en, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("t2.drain[%0d].enable", k), a_en, 1'b1);
            check($sformatf("t2.drain[%0d].data", k), a_data, 100 + k);
            check($sformatf("t2.drain[%0d].ready", k), a_ready, 1'b1);
        end
        step();
        check("t2.after.enable", a_en, 1'b0);
        check("t2.after.count", a_count, 0);

        // ---------- Test 3: two single-sample frames, gap 2 (dut_a) vs gap 0 (dut_b) ----------
        do_reset();
        drive(1'b1, 1'b1, 32'd5, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b1, 32'd6, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        begin
            bit a_en_exp [6] = '{1, 0, 0, 1, 0, 0};
            bit a_dn_exp [6] = '{0, 1, 0, 0, 1, 0};
            bit b_en_exp [6] = '{1, 1, 0, 0, 0, 0};
            bit b_dn_exp [6] = '{0, 1, 1, 0, 0, 0};
            for (int i = 0; i < 6; i++) begin
                step();
                check($sformatf("t3[%0d].a_enable", i), a_en, a_en_exp[i]);
                check($sformatf("t3[%0d].a_done", i), a_done, a_dn_exp[i]);
                check($sformatf("t3[%0d].b_enable", i), b_en, b_en_exp[i]);
                check($sformatf("t3[%0d].b_done", i), b_done, b_dn_exp[i]);
                if (i == 0) check("t3.a_data0", a_data, 5);
                if (i == 3) check("t3.a_data1", a_data, 6);
                if (i == 1) check("t3.b_data1", b_data, 6);
                if (a_dn_exp[i]) check($sformatf("t3[%0d].a_len", i), a_len, 1);
                if (b_dn_exp[i]) check($sformatf("t3[%0d].b_len", i), b_len, 1);
            end
        end

        // ---------- Test 4: hold for 3 cycles after the first pop ----------
        do_reset();
        drive(1'b1, 1'b1, 32'd1, 1'b0, 1'b1); step();
        drive(1'b1, 1'b1, 32'd2, 1'b0, 1'b1); step();
        drive(1'b1, 1'b1, 32'd3, 1'b1, 1'b1); step();
        begin
            bit hold_seq [6] = '{0, 1, 1, 1, 0, 0};
            bit en_exp   [6] = '{1, 0, 0, 0, 1, 1};
            for (int i = 0; i < 6; i++) begin
                drive(1'b1, 1'b0, '0, 1'b0, hold_seq[i]);
                step();
                check($sformatf("t4[%0d].enable", i), a_en, en_exp[i]);
            end
        end
        check("t4.last.data", a_data, 3);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step();
        check("t4.done", a_done, 1'b1);
        check("t4.len", a_len, 3);

        // ---------- Test 5: reset after 2 pops of a 4-sample frame ----------
        step(); step(); step();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, DW'(11 + k), k == 3, 1'b1);
            step();
        end
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        check("t5.pre.data", a_data, 12);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step();
        check("t5.rst.enable", a_en, 1'b0);
        check("t5.rst.data", a_data, 0);
        check("t5.rst.done", a_done, 1'b0);
        check("t5.rst.len", a_len, 0);
        check("t5.rst.count", a_count, 0);
        check("t5.rst.ready", a_ready, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t5.post[%0d].done", i), a_done, 1'b0);
            check($sformatf("t5.post[%0d].enable", i), a_en, 1'b0);
        end

        // ---------- Test 6: 20-sample frame, length saturates at 15 on dut_a ----------
        do_reset();
        begin
            int   en_cnt = 0;
            logic seen   = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                drive(1'b1, 1'b1, DW'(k), k == 20, 1'b0);
                step();
                if (a_en) en_cnt++;
            end
            drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
            for (int i = 0; i < 60 && !seen; i++) begin
                step();
                if (a_en) en_cnt++;
                if (a_done) begin
                    seen = 1'b1;
                    check("t6.a_len", a_len, 15);
                    check("t6.b_done", b_done, 1'b1);
                    check("t6.b_len", b_len, 20);
                end
            end
            check("t6.done_seen", seen, 1'b1);
            check("t6.pops", en_cnt, 20);
        end

        // ---------- Randomized traffic against the reference model ----------
        do_reset();
        model_clear();
        for (int i = 0; i < 3000; i++) begin
            logic          r, v, l, h;
            logic [DW-1:0] d;
            r = ($urandom_range(0, 149) != 0);
            v = ($urandom_range(0, 9) < 6);
            d = $urandom;
            l = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 99) < ((i < 1500) ? 50 : 15));
            drive(r, v, d, l, h);
            model_edge(r, v, d, l, h);
            step();
            check($sformatf("rnd[%0d].enable", i), a_en, e_en);
            check($sformatf("rnd[%0d].done", i), a_done, e_done);
            check($sformatf("rnd[%0d].len", i), a_len, e_len);
            check($sformatf("rnd[%0d].count", i), a_count, mq.size());
            check($sformatf("rnd[%0d].ready", i), a_ready, r && (mq.size() != DEPTH));
            if (e_en) check($sformatf("rnd[%0d].data", i), a_data, e_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
